// File: rtl/fp_adder.sv
`default_nettype none
// ============================================================================
// Module      : fp_adder
// Description : Three-stage pipelined IEEE-754 binary32 adder. Denormals are
//               flushed to zero. Truncating by default; defining
//               FP_ADDER_ROUND_NEAREST_EN selects round-to-nearest-even.
//               Latency: operands sampled at edge k appear after edge k+2.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_adder (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] N1,
   input  logic [31:0] N2,
   input  logic        valid,
   output logic [31:0] result
);

   localparam logic [31:0] QNAN_VAL = 32'h7FC0_0000;

   // ---------------- stage 0 (combinational) ----------------
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
   logic [31:0] x_op, y_op;
   logic [7:0]  exp_diff;
   logic [4:0]  shamt;
   logic [53:0] align;
   logic        spec_d, sign_d, sub_d;
   logic [31:0] spec_val_d;
   logic [7:0]  exp_d;
   logic [26:0] mx_d, my_d;

   // ---------------- stage 1 registers ----------------
   logic        v1_q, spec1_q, sign1_q, sub1_q;
   logic [31:0] spec_val1_q;
   logic [7:0]  exp1_q;
   logic [26:0] mx1_q, my1_q;

   // ---------------- stage 2 ----------------
   logic [27:0] sum_d;
   logic        v2_q, spec2_q, sign2_q, sub2_q;
   logic [31:0] spec_val2_q;
   logic [7:0]  exp2_q;
   logic [27:0] sum2_q;

   // ---------------- stage 3 ----------------
   logic [4:0]  lzc;
   logic [26:0] norm_m;
   logic [9:0]  norm_e, fin_e;
   logic        round_up, underflow, overflow;
   logic [24:0] rnd_m;
   logic [22:0] fin_frac;
   logic [31:0] result_d, result_q;

   // Classify operands, pick special-case results, order by magnitude, align Y
   always_comb begin
      a_nan  = (N1[30:23] == 8'hFF) && (N1[22:0] != 23'd0);
      b_nan  = (N2[30:23] == 8'hFF) && (N2[22:0] != 23'd0);
      a_inf  = (N1[30:23] == 8'hFF) && (N1[22:0] == 23'd0);
      b_inf  = (N2[30:23] == 8'hFF) && (N2[22:0] == 23'd0);
      a_zero = (N1[30:23] == 8'd0);
      b_zero = (N2[30:23] == 8'd0);
      // exponent is the upper field, so a plain compare orders exp then mantissa
      a_big  = (N1[30:0] >= N2[30:0]);

      spec_d     = 1'b1;
      spec_val_d = 32'd0;
      if (a_nan || b_nan)          spec_val_d = QNAN_VAL;
      else if (a_inf && b_inf)     spec_val_d = (N1[31] != N2[31]) ? QNAN_VAL : N1;
      else if (a_inf)              spec_val_d = N1;
      else if (b_inf)              spec_val_d = N2;
      else if (a_zero && b_zero)   spec_val_d = 32'd0;
      else if (a_zero)             spec_val_d = N2;
      else if (b_zero)             spec_val_d = N1;
      else                         spec_d     = 1'b0;

      x_op     = a_big ? N1 : N2;
      y_op     = a_big ? N2 : N1;
      exp_diff = x_op[30:23] - y_op[30:23];
      shamt    = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
      // 24-bit mantissa, 3 GRS bits, then 27 bits of catch area for the sticky
      align    = {1'b1, y_op[22:0], 30'd0} >> shamt;

      sign_d = x_op[31];
      sub_d  = x_op[31] ^ y_op[31];
      exp_d  = x_op[30:23];
      mx_d   = {1'b1, x_op[22:0], 3'b000};
      my_d   = {align[53:28], align[27] | (|align[26:0])};
   end

   // Stage 1: capture unpacked, ordered and aligned operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q        <= 1'b0;
         spec1_q     <= 1'b0;
         spec_val1_q <= '0;
         sign1_q     <= 1'b0;
         sub1_q      <= 1'b0;
         exp1_q      <= '0;
         mx1_q       <= '0;
         my1_q       <= '0;
      end else if (enable) begin
         v1_q        <= valid;
         spec1_q     <= spec_d;
         spec_val1_q <= spec_val_d;
         sign1_q     <= sign_d;
         sub1_q      <= sub_d;
         exp1_q      <= exp_d;
         mx1_q       <= mx_d;
         my1_q       <= my_d;
      end
   end

   // Mantissa add or subtract; X >= Y so subtraction never goes negative
   always_comb begin
      if (sub1_q) sum_d = {1'b0, mx1_q} - {1'b0, my1_q};
      else        sum_d = {1'b0, mx1_q} + {1'b0, my1_q};
   end

   // Stage 2: capture the raw sum with its exponent and sign
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q        <= 1'b0;
         spec2_q     <= 1'b0;
         spec_val2_q <= '0;
         sign2_q     <= 1'b0;
         sub2_q      <= 1'b0;
         exp2_q      <= '0;
         sum2_q      <= '0;
      end else if (enable) begin
         v2_q        <= v1_q;
         spec2_q     <= spec1_q;
         spec_val2_q <= spec_val1_q;
         sign2_q     <= sign1_q;
         sub2_q      <= sub1_q;
         exp2_q      <= exp1_q;
         sum2_q      <= sum_d;
      end
   end

   // Normalize, round, and resolve zero / underflow / overflow
   always_comb begin
      lzc = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (sum2_q[i]) lzc = 5'(26 - i);
      end

      if (!sub2_q && sum2_q[27]) begin
         norm_m = {sum2_q[27:2], sum2_q[1] | sum2_q[0]};
         norm_e = {2'b00, exp2_q} + 10'd1;
      end else if (!sub2_q) begin
         norm_m = sum2_q[26:0];
         norm_e = {2'b00, exp2_q};
      end else begin
         norm_m = sum2_q[26:0] << lzc;
         norm_e = {2'b00, exp2_q} - {5'd0, lzc};
      end

`ifdef FP_ADDER_ROUND_NEAREST_EN
      round_up = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
`else
      round_up = 1'b0;
`endif
      rnd_m = {1'b0, norm_m[26:3]} + {24'd0, round_up};
      if (rnd_m[24]) begin
         fin_frac = rnd_m[23:1];
         fin_e    = norm_e + 10'd1;
      end else begin
         fin_frac = rnd_m[22:0];
         fin_e    = norm_e;
      end

      // norm_e wraps to a large value with bit 9 set when it goes negative
      underflow = norm_e[9] || (norm_e == 10'd0);
      overflow  = !fin_e[9] && (fin_e >= 10'd255);

      if (spec2_q)                 result_d = spec_val2_q;
      else if (norm_m == 27'd0)    result_d = 32'd0;
      else if (underflow)          result_d = {sign2_q, 31'd0};
      else if (overflow)           result_d = {sign2_q, 8'hFF, 23'd0};
      else                         result_d = {sign2_q, fin_e[7:0], fin_frac};
   end

   // Stage 3: commit the result for valid slots only
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  result_q <= '0;
      else if (enable && v2_q)  result_q <= result_d;
   end

   assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_adder
// Description : Scoreboard bench for fp_adder. Expected sums are queued when
//               operands are driven and compared when they reach the output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] N1 = 32'd0;
   logic [31:0] N2 = 32'd0;
   logic [31:0] result;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];
   logic [31:0] model_res = 32'd0;
   logic [31:0] ta[$], tbv[$], ty[$];

   fp_adder dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .N1     (N1),
      .N2     (N2),
      .valid  (valid),
      .result (result)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one cycle of stimulus; an enabled cycle queues the value result should hold
   task automatic drive(input logic en, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] y);
      enable = en;
      valid  = v;
      N1     = a;
      N2     = b;
      if (en) begin
         if (v) model_res = y;
         sb.push_back(model_res);
      end
   endtask

   task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] y);
      ta.push_back(a);
      tbv.push_back(b);
      ty.push_back(y);
   endtask

   task automatic test_reset();
      logic [31:0] want;
      rst = 1'b1; enable = 1'b1; valid = 1'b1; N1 = 32'h3F80_0000; N2 = 32'h3F80_0000;
      repeat (3) @(negedge clk);
      checks++;
      if (result !== 32'd0) begin
         errors++;
         $display("FAIL reset_hold: result=%08h expected=00000000", result);
      end
      valid = 1'b0;
      rst   = 1'b0;
      sb.delete();
      sb.push_back(32'd0);
      sb.push_back(32'd0);
      model_res = 32'd0;
      drive(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (sb.size() == 3) begin
            want = sb.pop_front();
            checks++;
            if (result !== want) begin
               errors++;
               $display("FAIL zero_plus_zero step %0d: result=%08h expected=%08h", i, result, want);
            end
         end
         drive(1'b1, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0);
      end
   endtask

   // Back-to-back vector stream, one operation per cycle
   task automatic test_arith();
      logic [31:0] want;
      int n = ta.size();
      for (int i = 0; i < n + 3; i++) begin
         @(negedge clk);
         if (sb.size() == 3) begin
            want = sb.pop_front();
            checks++;
            if (result !== want) begin
               errors++;
               $display("FAIL arith vec %0d: result=%08h expected=%08h", i - 3, result, want);
            end
         end
         if (i < n) drive(1'b1, 1'b1, ta[i], tbv[i], ty[i]);
         else       drive(1'b1, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0);
      end
   endtask

   // Operations separated by valid=0 slots carrying live-looking operands
   task automatic test_bubble();
      logic [31:0] want;
      logic        pv [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] pa [8] = '{32'h3FC0_0000, 32'h4000_0000, 32'h4120_0000, 32'h41CA_0000,
                              32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000};
      logic [31:0] pb [8] = '{32'h3FC0_0000, 32'h4000_0000, 32'h4120_0000, 32'h41CA_0000,
                              32'h4000_0000, 32'hBF40_0000, 32'h4000_0000, 32'h4000_0000};
      logic [31:0] py [8] = '{32'h4040_0000, 32'h0, 32'h0, 32'h424A_0000,
                              32'h0, 32'h3E80_0000, 32'h0, 32'h0};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (sb.size() == 3) begin
            want = sb.pop_front();
            checks++;
            if (result !== want) begin
               errors++;
               $display("FAIL bubble step %0d: result=%08h expected=%08h", i, result, want);
            end
         end
         if (i < 8) drive(1'b1, pv[i], pa[i], pb[i], py[i]);
         else       drive(1'b1, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0);
      end
   endtask

   // Two-cycle enable=0 window with two operations in flight
   task automatic test_enable_freeze();
      logic [31:0] want;
      logic [31:0] held;
      held = 32'd0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (sb.size() == 3) begin
            want = sb.pop_front();
            held = want;
            checks++;
            if (result !== want) begin
               errors++;
               $display("FAIL freeze_stream step %0d: result=%08h expected=%08h", i, result, want);
            end
         end else begin
            checks++;
            if (result !== held) begin
               errors++;
               $display("FAIL freeze_hold step %0d: result=%08h expected=%08h", i, result, held);
            end
         end
         case (i)
            0:       drive(1'b1, 1'b1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
            1:       drive(1'b1, 1'b1, 32'h40A0_0000, 32'h3F80_0000, 32'h40C0_0000);
            2, 3:    drive(1'b0, 1'b1, 32'h4120_0000, 32'h4120_0000, 32'h0);
            default: drive(1'b1, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0);
         endcase
      end
   endtask

   // Reset asserted between edges with operations in flight
   task automatic test_reset_midstream();
      logic [31:0] want;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (sb.size() == 3) begin
            want = sb.pop_front();
            checks++;
            if (result !== want) begin
               errors++;
               $display("FAIL pre_reset step %0d: result=%08h expected=%08h", i, result, want);
            end
         end
         case (i)
            0:       drive(1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
            1:       drive(1'b1, 1'b1, 32'h4040_0000, 32'h4040_0000, 32'h40C0_0000);
            default: drive(1'b1, 1'b1, 32'h41CA_0000, 32'h41CA_0000, 32'h424A_0000);
         endcase
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (result !== 32'd0) begin
         errors++;
         $display("FAIL reset_async: result=%08h expected=00000000", result);
      end
      @(negedge clk);
      valid = 1'b0;
      rst   = 1'b0;
      sb.delete();
      sb.push_back(32'd0);
      sb.push_back(32'd0);
      model_res = 32'd0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) drive(1'b1, 1'b1, 32'hC1C9_CEA5, 32'hC197_037B, 32'hC230_6910);
         else        drive(1'b1, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0);
         @(negedge clk);
         if (sb.size() == 3) begin
            want = sb.pop_front();
            checks++;
            if (result !== want) begin
               errors++;
               $display("FAIL post_reset step %0d: result=%08h expected=%08h", i, result, want);
            end
         end
      end
   endtask

   initial begin
      add_vec(32'h41CA_0000, 32'hC1CA_0000, 32'h0000_0000);
      add_vec(32'h41CA_0000, 32'h0000_0000, 32'h41CA_0000);
      add_vec(32'h3556_BF95, 32'hB571_9787, 32'hB3D6_BF90);
      add_vec(32'hB571_9787, 32'h3556_BF95, 32'hB3D6_BF90);
      add_vec(32'h41CA_0000, 32'h41CA_0000, 32'h424A_0000);
      add_vec(32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000);
      add_vec(32'hC1C9_CEA5, 32'hC197_037B, 32'hC230_6910);
      add_vec(32'h4E57_19EB, 32'h33C1_BEF8, 32'h4E57_19EB);
      add_vec(32'h33C1_BEF8, 32'h4E57_19EB, 32'h4E57_19EB);
      add_vec(32'h3F80_0000, 32'hBF40_0000, 32'h3E80_0000);
      add_vec(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
      add_vec(32'h3F80_0000, 32'h7F80_0001, 32'h7FC0_0000);
      add_vec(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
      add_vec(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
      add_vec(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
      add_vec(32'h0080_0000, 32'h8080_0001, 32'h8000_0000);
      add_vec(32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
      add_vec(32'h8000_0000, 32'h40A0_0000, 32'h40A0_0000);
`ifdef FP_ADDER_ROUND_NEAREST_EN
      add_vec(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
      add_vec(32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001);
`else
      add_vec(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0001);
      add_vec(32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0000);
`endif

      test_reset();
      test_arith();
      test_bubble();
      test_enable_freeze();
      test_reset_midstream();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fp_adder.md
# fp_adder

Pipelined IEEE-754 single-precision floating-point adder. It takes two 32-bit operands, adds them with sign handling (subtraction occurs when the signs differ), and delivers a normalized 32-bit result three clock edges later. It is a standalone arithmetic datapath block and has no output handshake: downstream logic samples `result` at a fixed latency.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: pipeline clock-enable. When low, all pipeline registers and `result` hold.
- `N1` input 32: operand A, IEEE-754 binary32.
- `N2` input 32: operand B, IEEE-754 binary32.
- `valid` input 1: marks `N1`/`N2` as a real operation in the cycle they are sampled.
- `result` output 32: registered sum A+B, binary32.

## Operation
- Unpack each operand: sign, 8-bit exponent, 23-bit fraction. Prepend the hidden 1 when exponent≠0.
- Exponent 0 (zero or denormal) is treated as signed zero; denormals are flushed to zero.
- Swap operands so that operand X has the larger magnitude: compare exponent first, then mantissa.
- Align: shift Y's 24-bit mantissa right by (expX−expY), saturating at 27 positions. Keep 3 extra low bits (guard/round/sticky); the sticky bit is the OR of all bits shifted out.
- Same signs: add mantissas into a 25-bit sum. On carry-out, shift right 1 and increment the exponent.
- Different signs: subtract Y from X. Result sign = sign of X.
  - Normalize using a leading-zero count (0–24).
  - Shift left and decrement the exponent by the count.
- Exact cancellation, or either operand being the other's negation, yields +0 (0x00000000).
- Zero operand: the result equals the other operand exactly. 0+0 yields +0.
- Underflow: if the normalized exponent is ≤0, the result is signed zero.
- Overflow: if the exponent is ≥255, the result is ±infinity (exp 0xFF, fraction 0).
- Special inputs:
  - Any NaN gives the quiet NaN 0x7FC00000.
  - +inf + −inf gives 0x7FC00000.
  - inf + finite gives that inf.
- Rounding: truncation (round toward zero) by default; see Configuration.

## Timing
- Three-stage pipeline. Each stage advances only on a rising edge with `enable`=1.
- Stage 1 registers the unpacked, swapped and aligned operands plus a `valid` bit.
- Stage 2 registers the add/sub result.
- Stage 3 normalizes and rounds. It loads `result` only if the stage-3 valid bit is 1.
- Latency: operands sampled at edge k appear on `result` after edge k+2. Throughput is one operation per cycle.
- `valid`=0 at sampling: a bubble propagates and `result` keeps its previous value.
- `enable`=0: complete freeze, including the valid bits. There is no loss or duplication of in-flight operations.
- Reset (any time, mid-operation included): all pipeline registers, valid bits and `result` clear to 0 immediately. In-flight operations are discarded.
- Operand changes between edges have no effect; only edge-sampled values matter.

## Configuration
- `FP_ADDER_ROUND_NEAREST_EN`: when defined, stage 3 rounds to nearest-even using guard/round/sticky.
  - Mantissa overflow from rounding renormalizes and increments the exponent. This can produce ±inf.
- When undefined: guard/round/sticky are discarded (truncation). Latency is identical in both builds.
- All Test-plan vectors pass in both builds.

## Test plan
- Reset to 0, then release. 0x00000000 + 0x00000000 with enable=valid=1 → result 0x00000000 after 3 edges.
- 0x41CA0000 (25.25) + 0xC1CA0000 (−25.25) → 0x00000000. 0x41CA0000 + 0x00000000 → 0x41CA0000.
- Cancellation normalization: 0x3556BF95 + 0xB5719787 → 0xB3D6BF90 (shift left 3).
- Same-sign overflow:
  - 0x41CA0000 + 0x41CA0000 → 0x424A0000.
  - 0x3FC00000 + 0x3FC00000 → 0x40400000.
  - 0xC1C9CEA5 + 0xC197037B → 0xC2306910.
- Large exponent gap: 0x4E5719EB + 0x33C1BEF8 → 0x4E5719EB.
- Control:
  - Back-to-back operations on consecutive edges each produce their result 2 edges later.
  - Holding enable=0 for 2 cycles mid-stream freezes `result`.
  - `valid`=0 bubble leaves `result` unchanged.
  - Asserting `rst` mid-stream clears `result` to 0 without waiting for a clock edge.
